// File: rtl/mest_pro_display_scan.sv
// Multi-digit 7-segment scan controller. Feeds one nibble at a time to a
// registered single-digit decoder, drives a one-hot digit select delayed one
// cycle to match the decoder latency, and blanks between digits.
module mest_pro_display_scan #(
    parameter int unsigned MEM_WIDTH    = 16,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_enable,
    input  logic                      i_load,
    input  logic [MEM_WIDTH-1:0]      i_value,
    input  logic                      i_lz_blank,
    output logic                      o_output_enable,
    output logic [3:0]                o_nibble,
    output logic [MEM_WIDTH/4-1:0]    o_digit_sel,
    output logic                      o_frame_done,
    output logic                      o_pending
);

    localparam int unsigned NUM_DIGITS = MEM_WIDTH / 4;
    localparam int unsigned CNT_MAX    = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int unsigned PW         = $clog2(CNT_MAX);
    localparam int unsigned DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] SHOW_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StShow
    } state_e;

    state_e                  state_q;
    logic [PW-1:0]           cnt_q;
    logic [DW-1:0]           digit_q;
    logic [MEM_WIDTH-1:0]    shadow_q;
    logic [MEM_WIDTH-1:0]    pend_val_q;
    logic                    pend_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic                    frame_done_q;

    logic                    show;
    logic                    commit;
    logic [MEM_WIDTH-1:0]    commit_val;
    logic [NUM_DIGITS-1:0]   commit_blank;
    logic [3:0]              cur_nibble;
    logic [NUM_DIGITS-1:0]   cur_sel;

    assign show = (state_q == StShow);

    // Entry to BLANK of digit 0, either from IDLE or at the end of a frame.
    assign commit = i_enable &&
                    ((state_q == StIdle) ||
                     (show && (cnt_q == SHOW_LAST) && (digit_q == DIGIT_LAST)));

    // A load coinciding with a commit bypasses the pending register.
    assign commit_val = i_load ? i_value : pend_val_q;

    // Leading-zero mask for the value about to be committed; digit 0 never blanks.
    always_comb begin
        logic seen_nz;
        seen_nz      = 1'b0;
        commit_blank = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            seen_nz         = seen_nz | (commit_val[4*k +: 4] != 4'd0);
            commit_blank[k] = i_lz_blank & ~seen_nz;
        end
    end

    // Select the current digit's nibble and its (undelayed) select bit.
    always_comb begin
        cur_nibble = 4'd0;
        cur_sel    = '0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (digit_q == DW'(k)) begin
                cur_nibble = shadow_q[4*k +: 4];
                cur_sel[k] = ~blank_q[k];
            end
        end
    end

    // Scan FSM, load/commit handling and registered select/frame outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            digit_q      <= '0;
            shadow_q     <= '0;
            pend_val_q   <= '0;
            pend_q       <= 1'b0;
            blank_q      <= '0;
            sel_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            sel_q        <= show ? cur_sel : '0;

            // pend_val_q always tracks the newest load so later commits recopy it.
            if (commit) begin
                shadow_q <= commit_val;
                blank_q  <= commit_blank;
                pend_q   <= 1'b0;
                if (i_load) begin
                    pend_val_q <= i_value;
                end
            end else if (i_load) begin
                pend_val_q <= i_value;
                pend_q     <= 1'b1;
            end

            if (!i_enable) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                digit_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StBlank;
                        cnt_q   <= '0;
                        digit_q <= '0;
                    end
                    StBlank: begin
                        if (cnt_q == BLANK_LAST) begin
                            state_q <= StShow;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StShow: begin
                        if (cnt_q == SHOW_LAST) begin
                            state_q <= StBlank;
                            cnt_q   <= '0;
                            if (digit_q == DIGIT_LAST) begin
                                digit_q      <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                digit_q <= digit_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        digit_q <= '0;
                    end
                endcase
            end
        end
    end

    assign o_output_enable = show & (|cur_sel);
    assign o_nibble        = show ? cur_nibble : 4'd0;
    assign o_digit_sel     = sel_q;
    assign o_frame_done    = frame_done_q;
    assign o_pending       = pend_q;

endmodule

// File: tb/tb_mest_pro_display_scan.sv
// Scoreboard bench for the display scan controller: stimulus queues expected
// output cycles and o_pending values, a negedge monitor pops and compares.
module tb_mest_pro_display_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic        i_load;
    logic [15:0] i_value;
    logic        i_lz_blank;
    logic        o_output_enable;
    logic [3:0]  o_nibble;
    logic [3:0]  o_digit_sel;
    logic        o_frame_done;
    logic        o_pending;

    mest_pro_display_scan #(
        .MEM_WIDTH    (16),
        .SCAN_DIV     (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_enable        (i_enable),
        .i_load          (i_load),
        .i_value         (i_value),
        .i_lz_blank      (i_lz_blank),
        .o_output_enable (o_output_enable),
        .o_nibble        (o_nibble),
        .o_digit_sel     (o_digit_sel),
        .o_frame_done    (o_frame_done),
        .o_pending       (o_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic       oe;
        logic [3:0] nib;
        logic [3:0] sel;
        logic       fd;
    } exp_t;

    typedef struct {
        int   c;
        logic v;
    } pexp_t;

    exp_t  q[$];
    pexp_t pq[$];
    int    vectors = 0;
    int    fails   = 0;
    logic  done    = 1'b0;

    task automatic push_out(input int c, input logic oe, input logic [3:0] nib,
                            input logic [3:0] sel, input logic fd);
        exp_t e;
        e.c = c; e.oe = oe; e.nib = nib; e.sel = sel; e.fd = fd;
        q.push_back(e);
    endtask

    task automatic push_pend(input int c, input logic v);
        pexp_t p;
        p.c = c; p.v = v;
        pq.push_back(p);
    endtask

    // Expected active cycles of one frame starting at base (first BLANK of digit 0).
    // Entries at or beyond base+limit are dropped (aborted frames).
    task automatic push_frame(input int base, input logic [15:0] val, input logic lz,
                              input logic fd, input int limit);
        int msd;
        msd = 0;
        for (int k = 0; k < 4; k++) if (val[4*k +: 4] != 4'd0) msd = k;
        for (int k = 0; k < 4; k++) begin
            int         s;
            logic [3:0] nb;
            logic [3:0] one;
            s   = base + 6 * k;
            nb  = val[4*k +: 4];
            one = 4'b0001 << k;
            if (!(lz && k > msd)) begin
                for (int j = 2; j <= 5; j++)
                    if (s + j < base + limit)
                        push_out(s + j, 1'b1, nb, (j == 2) ? 4'b0000 : one, 1'b0);
                if (s + 6 < base + limit)
                    push_out(s + 6, 1'b0, 4'h0, one, (k == 3) && fd);
            end else if (k == 3 && fd && (s + 6 < base + limit)) begin
                push_out(s + 6, 1'b0, 4'h0, 4'b0000, 1'b1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask

    // Monitor: compares every cycle in which the DUT drives anything non-zero.
    exp_t  e;
    pexp_t p;
    logic  active;
    always @(negedge clk) begin
        if (cyc > 0) begin
            while (q.size() > 0 && q[0].c < cyc) begin
                e = q.pop_front();
                vectors++;
                fails++;
                $display("FAIL missing_output @cyc %0d: got nothing, required oe=%b nib=%h sel=%b fd=%b",
                         e.c, e.oe, e.nib, e.sel, e.fd);
            end
            active = (o_output_enable !== 1'b0) || (o_nibble !== 4'h0) ||
                     (o_digit_sel !== 4'h0) || (o_frame_done !== 1'b0);
            if (active) begin
                vectors++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output @cyc %0d: got oe=%b nib=%h sel=%b fd=%b, required all 0",
                             cyc, o_output_enable, o_nibble, o_digit_sel, o_frame_done);
                end else begin
                    e = q.pop_front();
                    if (e.c != cyc || e.oe !== o_output_enable || e.nib !== o_nibble ||
                        e.sel !== o_digit_sel || e.fd !== o_frame_done) begin
                        fails++;
                        $display("FAIL scan_output @cyc %0d: got oe=%b nib=%h sel=%b fd=%b, required oe=%b nib=%h sel=%b fd=%b @cyc %0d",
                                 cyc, o_output_enable, o_nibble, o_digit_sel, o_frame_done,
                                 e.oe, e.nib, e.sel, e.fd, e.c);
                    end
                end
            end
            while (pq.size() > 0 && pq[0].c <= cyc) begin
                p = pq.pop_front();
                vectors++;
                if (p.c != cyc || o_pending !== p.v) begin
                    fails++;
                    $display("FAIL pending @cyc %0d: got %b, required %b @cyc %0d",
                             cyc, o_pending, p.v, p.c);
                end
            end
        end
        if (done || cyc > 2000) begin
            if (!done) begin
                fails++;
                $display("FAIL timeout @cyc %0d: stimulus did not complete", cyc);
            end
            while (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                fails++;
                $display("FAIL missing_output @cyc %0d: got nothing, required oe=%b nib=%h sel=%b fd=%b",
                         e.c, e.oe, e.nib, e.sel, e.fd);
            end
            while (pq.size() > 0) begin
                p = pq.pop_front();
                vectors++;
                fails++;
                $display("FAIL pending @cyc %0d: got no check, required %b", p.c, p.v);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
            $finish;
        end
    end

    initial begin
        int a, c, d, ef, f, g, h, i, j, k;
        rst = 1'b1; i_enable = 1'b0; i_load = 1'b0; i_value = 16'h0; i_lz_blank = 1'b0;
        push_pend(2, 1'b0);
        goto(4);
        rst = 1'b0;

        // 1: enable, first frame shows 0, then 0x1234
        goto(6);
        i_enable = 1'b1;
        a = 7;
        push_frame(a, 16'h0000, 1'b0, 1'b1, 99);
        push_frame(a + 24, 16'h1234, 1'b0, 1'b1, 99);
        c = a + 48;
        d = c + 24;
        push_frame(c, 16'h1234, 1'b0, 1'b1, 99);
        push_frame(d, 16'h00F0, 1'b0, 1'b1, 99);
        goto(a + 4);
        i_load = 1'b1; i_value = 16'h1234;
        push_pend(a + 5, 1'b1); push_pend(a + 23, 1'b1); push_pend(a + 24, 1'b0);
        tick();
        i_load = 1'b0;

        // 2: back-to-back loads while digit 2 is shown; last one wins
        goto(c + 15);
        i_load = 1'b1; i_value = 16'hABCD;
        push_pend(c + 16, 1'b1); push_pend(c + 23, 1'b1); push_pend(c + 24, 1'b0);
        tick();
        i_value = 16'h00F0;
        tick();
        i_load = 1'b0;

        // 3: leading-zero blanking, then an all-zero value
        goto(d + 3);
        i_lz_blank = 1'b1;
        ef = d + 24;
        f  = ef + 24;
        push_frame(ef, 16'h00F0, 1'b1, 1'b1, 99);
        push_frame(f, 16'h0000, 1'b1, 1'b1, 99);
        goto(ef + 5);
        i_load = 1'b1; i_value = 16'h0000;
        push_pend(ef + 6, 1'b1); push_pend(ef + 23, 1'b1); push_pend(ef + 24, 1'b0);
        tick();
        i_load = 1'b0;
        goto(f + 3);
        i_lz_blank = 1'b0;

        // 4: load on the commit cycle bypasses pending
        g = f + 24;
        h = g + 24;
        push_frame(g, 16'h5555, 1'b0, 1'b1, 99);
        // 5: enable drops during SHOW of digit 1
        push_frame(h, 16'h5555, 1'b0, 1'b0, 10);
        push_out(h + 10, 1'b0, 4'h0, 4'b0010, 1'b0);
        push_pend(f + 23, 1'b0); push_pend(f + 24, 1'b0); push_pend(f + 25, 1'b0);
        goto(f + 23);
        i_load = 1'b1; i_value = 16'h5555;
        tick();
        i_load = 1'b0;
        goto(h + 9);
        i_enable = 1'b0;
        goto(h + 14);
        i_enable = 1'b1;
        i = h + 15;
        j = i + 24;
        push_pend(i, 1'b0);
        push_frame(i, 16'h5555, 1'b0, 1'b1, 99);
        push_frame(j, 16'h5555, 1'b0, 1'b0, 9);

        // 6: reset mid-frame with a pending value
        goto(j + 3);
        i_load = 1'b1; i_value = 16'h9876;
        push_pend(j + 4, 1'b1);
        tick();
        i_load = 1'b0;
        goto(j + 8);
        rst = 1'b1; i_enable = 1'b0;
        push_pend(j + 9, 1'b0); push_pend(j + 10, 1'b0);
        goto(j + 10);
        rst = 1'b0;
        goto(j + 12);
        i_enable = 1'b1;
        k = j + 13;
        push_frame(k, 16'h0000, 1'b0, 1'b0, 25);
        // abort at the last SHOW cycle: no frame_done
        goto(k + 23);
        i_enable = 1'b0;
        goto(k + 30);
        done = 1'b1;
    end

endmodule

// File: doc/mest_pro_display_scan.md
Name: mest_pro_display_scan

Overview:
- Time-multiplexed scan controller for the team's single-digit 7-segment decoder, which has a registered output and a 1-cycle latency. It drives a multi-digit common-cathode display.
- Splits a MEM_WIDTH-bit value into 4-bit nibbles and feeds one nibble at a time to the decoder, with the decoder's output enable asserted.
- Drives the one-hot digit select, aligned to the decoder latency, and inserts a blanking gap between digits to prevent ghosting.
- New values commit only at frame boundaries, so the display never shows a mix of old and new digits.

Parameters:
MEM_WIDTH, 16, width of the displayed value; must be a multiple of 4; NUM_DIGITS = MEM_WIDTH/4 (localparam)
SCAN_DIV, 1000, clock cycles each digit is shown (>=2)
BLANK_CYCLES, 8, clock cycles of blanking before each digit (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
i_enable  input  1  1 = scan running; 0 = display dark
i_load  input  1  single-cycle pulse: capture i_value
i_value  input  MEM_WIDTH  value to display; nibble 0 = bits [3:0] = rightmost digit
i_lz_blank  input  1  1 = suppress leading zero digits
o_output_enable  output  1  to decoder i_output_enable
o_nibble  output  4  to decoder i_mem_val (zero-extended by the instantiating module)
o_digit_sel  output  NUM_DIGITS  one-hot digit drive, active high, bit k = digit k
o_frame_done  output  1  1-cycle pulse at the end of each full frame
o_pending  output  1  a loaded value is waiting for the next frame boundary

Behaviour:
- Reset: state IDLE; prescaler, digit index, shadow and pending registers cleared. All outputs 0 on the cycle after rst is sampled high. Reset mid-frame discards any pending value.
- States:
  - IDLE -> BLANK (digit 0) when i_enable = 1.
  - BLANK: lasts BLANK_CYCLES cycles, then -> SHOW.
  - SHOW: lasts SCAN_DIV cycles. Then -> BLANK of digit+1; after digit NUM_DIGITS-1, -> BLANK of digit 0.
  - Any state -> IDLE on the cycle i_enable = 0 is sampled. Re-enable always restarts at BLANK, digit 0, with counters cleared.
- Outputs per state:
  - BLANK and IDLE: o_output_enable = 0, o_nibble = 0.
  - SHOW of digit k: o_output_enable = 1 (unless k is blanked, see below), o_nibble = shadow[4k+3:4k].
- Digit-select alignment: o_digit_sel is the internal select delayed by one register stage, so it lines up with the decoder's 1-cycle output latency. Bit k is high from SHOW cycle 2 through the first BLANK cycle of the next digit, i.e. exactly SCAN_DIV cycles. After i_enable drops, o_digit_sel goes to 0 one cycle after o_output_enable does.
- Load:
  - i_load captures i_value into the pending register and sets o_pending on the next cycle.
  - Back-to-back loads: the last one wins.
  - Commit: on entry to BLANK of digit 0 (including IDLE -> BLANK), pending is copied to shadow and o_pending clears.
  - i_load in the same cycle as a commit: the i_value from that cycle is committed directly, and o_pending stays 0.
  - i_load while in IDLE: the value is held pending until the scan starts.
- o_frame_done: pulses on the cycle SHOW of digit NUM_DIGITS-1 exits to BLANK of digit 0. No pulse if the frame is aborted by i_enable = 0.
- Leading-zero blanking: evaluated on the shadow register at commit time. With i_lz_blank = 1, every digit above the most-significant non-zero nibble is scanned with full timing but has o_output_enable = 0 and its o_digit_sel bit held 0. Digit 0 is never blanked, so a shadow value of 0 shows "0". i_lz_blank is sampled at commit.
- Counter widths: prescaler is $clog2(max(SCAN_DIV, BLANK_CYCLES)) bits; digit index is $clog2(NUM_DIGITS) bits, minimum 1. Both wrap to 0, never past their terminal count.
- At most one o_digit_sel bit is high in any cycle.

Test Plan:
Bench configuration for all scenarios: MEM_WIDTH=16, SCAN_DIV=4, BLANK_CYCLES=2 (6 cycles per digit, 24-cycle frame).
1. Reset and enable, then i_load 0x1234 -> outputs 0 through reset; first frame shows shadow 0 (digits 0-3 all nibble 0). Next frame shows nibbles 4,3,2,1 on digits 0-3; o_digit_sel sequence 0001, 0010, 0100, 1000, each high for 4 cycles, starting 1 cycle after o_output_enable rises; o_frame_done pulses every 24 cycles.
2. Mid-frame loads 0xABCD then 0x00F0 while digit 2 is shown -> current frame keeps the old value; o_pending = 1 until the next digit-0 BLANK; the next frame shows 0,F,0,0 (0x00F0 wins).
3. i_lz_blank = 1 with value 0x00F0 -> digits 0 and 1 enabled (nibbles 0, F); digits 2 and 3 have o_output_enable = 0 and select 0; frame is still 24 cycles. Value 0x0000 -> only digit 0 lit, showing 0.
4. i_load asserted on the exact cycle of a frame-boundary commit with 0x5555 -> the following frame shows 5,5,5,5; o_pending never rises.
5. Drop i_enable during SHOW of digit 1 -> next cycle o_output_enable = 0; the cycle after, o_digit_sel = 0; no o_frame_done. Re-enable -> restarts at BLANK, digit 0.
6. Assert rst mid-frame with o_pending = 1 -> all outputs 0; pending cleared; after release and enable, display shows 0000.
